ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter; the send side of the keyboard port whose receive side is already in the system.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side command channel of the PS/2 transmitter.
// master: the block that issues command bytes; slave: ps2_host_tx itself.
interface ps2_host_tx_if;
    logic [7:0] tx_data;   // byte to send
    logic       tx_valid;  // request, taken when tx_valid && tx_ready
    logic       tx_ready;  // transmitter idle and able to accept
    logic       tx_done;   // one-cycle pulse: frame sent, device acknowledged
    logic       tx_error;  // one-cycle pulse: timeout or bad acknowledge
    logic       busy;      // host frame in progress; receiver must ignore the line

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error, busy
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter (send side of the keyboard port).
// Frame: inhibit clock, request-to-send, shift 8 data + odd parity + stop
// on device clock falls, then check the device acknowledge bit.
// Pin outputs are pull-low enables for open-collector pads.
// Optional feature: define PS2_TX_GLITCH_FILTER_EN to debounce the synced
// PS/2 clock over FILTER_CYC samples before edge detection.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15_000,
    parameter int unsigned FILTER_CYC  = 8
) (
    input  logic         clk_chipset,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    // 64-bit arithmetic: TIMEOUT_US * CLK_FREQ_HZ overflows 32 bits at default values.
    localparam logic [63:0] INHIBIT_CYC = 64'(INHIBIT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam logic [63:0] TIMEOUT_CYC = 64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam int          TO_W        = $clog2(TIMEOUT_CYC + 64'd1);
    localparam logic [TO_W-1:0] INH_LAST = TO_W'(INHIBIT_CYC - 64'd1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 64'd1);

    // The frame counter doubles as the inhibit timer, so inhibit must end well before timeout.
    if (FILTER_CYC == 0 || INHIBIT_CYC == 0 || INHIBIT_CYC >= TIMEOUT_CYC) begin : g_bad_cfg
        $error("ps2_host_tx: inconsistent timing parameters");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      shreg_q, shreg_d;     // {stop, parity, data}, LSB goes out first
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0] to_q, to_d;           // cycles since accept
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic clk_lvl;      // conditioned clock level used for edge detection
    logic clk_lvl_q;    // clk_lvl one cycle earlier
    logic fall;

    // Two-flop synchronizers for the asynchronous pin levels; idle bus reads high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILTER_CYC + 1);
    logic [FC_W-1:0] flt_cnt_q;
    logic            clk_flt_q;

    // Adopt a new clock level only after FILTER_CYC consecutive samples disagree with the held one.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            flt_cnt_q <= '0;
            clk_flt_q <= 1'b1;
        end else if (clk_sync_q == clk_flt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FC_W'(FILTER_CYC - 1)) begin
            flt_cnt_q <= '0;
            clk_flt_q <= clk_sync_q;
        end else begin
            flt_cnt_q <= flt_cnt_q + FC_W'(1);
        end
    end

    assign clk_lvl = clk_flt_q;
`else
    assign clk_lvl = clk_sync_q;
`endif

    // Previous clock level, for falling-edge detection.
    always_ff @(posedge clk_chipset) begin
        if (reset) clk_lvl_q <= 1'b1;
        else       clk_lvl_q <= clk_lvl;
    end

    assign fall = clk_lvl_q & ~clk_lvl;

    // Frame state and registered pin/pulse outputs (registered so the pads never glitch).
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            to_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            to_q      <= to_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic: timeout overrides any clock event in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        to_d      = to_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (state_q != ST_IDLE) begin
            to_d = to_q + TO_W'(1);
        end

        if (state_q != ST_IDLE && to_q == TO_LAST) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            error_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    if (tx.tx_valid) begin
                        shreg_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
                        to_d     = '0;
                        clk_oe_d = 1'b1;
                        state_d  = ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (to_q == INH_LAST) begin
                        data_oe_d = 1'b1;   // start bit
                        state_d   = ST_REQ;
                    end
                end
                ST_REQ: begin
                    clk_oe_d  = 1'b0;       // hand the clock to the device
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (fall) begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (fall) begin
                        if (data_sync_q) begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clk_lvl && data_sync_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready  = (state_q == ST_IDLE);
    assign tx.busy      = (state_q != ST_IDLE);
    assign tx.tx_done   = done_q;
    assign tx.tx_error  = error_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;

endmodule
